// File: rtl/vx_slot_alloc_pkg.sv
// Shared helpers for the slot allocator: ID-width derivation used by the top and its encoder.
package vx_slot_alloc_pkg;

    // Rounded-up log2 with a floor of one bit, so a single-slot table still has a 1-bit ID.
    function automatic int up_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_slot_alloc_priority_encoder.sv
// First-set-bit encoder: lowest set index (or highest when REVERSE) plus an any-set flag.
module vx_slot_alloc_priority_encoder
    import vx_slot_alloc_pkg::*;
#(
    parameter int N       = 8,
    parameter int REVERSE = 0,
    parameter int LN      = up_clog2(N)
) (
    input  logic [N-1:0]  data_in,
    output logic [LN-1:0] index,
    output logic          valid
);

    always_comb begin
        index = '0;
        valid = |data_in;
        if (REVERSE != 0) begin
            // Ascending scan: the last hit is the highest set index.
            for (int i = 0; i < N; i++) begin
                if (data_in[i]) index = LN'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (data_in[i]) index = LN'(i);
            end
        end
    end

endmodule

// File: rtl/vx_slot_alloc.sv
// Slot allocator: grants the first free slot of SIZE, accepts one release per cycle by index.
module vx_slot_alloc
    import vx_slot_alloc_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int REVERSE = 0,
    parameter int LOGS    = up_clog2(SIZE)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      acquire_valid,
    output logic                      acquire_ready,
    output logic [LOGS-1:0]           acquire_id,
    input  logic                      release_valid,
    input  logic [LOGS-1:0]           release_id,
    output logic [$clog2(SIZE+1)-1:0] count,
    output logic                      empty,
    output logic                      full
);

    localparam int CNTW = $clog2(SIZE + 1);

    logic [SIZE-1:0] busy_reg, busy_next;
    logic [CNTW-1:0] count_reg, count_next;
    logic            empty_reg, full_reg;
    logic            alive_reg;
    logic [LOGS-1:0] free_id;
    logic            free_valid;
    logic            acquire_fire;

    vx_slot_alloc_priority_encoder #(
        .N       (SIZE),
        .REVERSE (REVERSE),
        .LN      (LOGS)
    ) free_enc (
        .data_in (~busy_reg),
        .index   (free_id),
        .valid   (free_valid)
    );

    // alive_reg keeps ready low through reset without a combinational path from the reset pin.
    assign acquire_ready = alive_reg && !full_reg;
    assign acquire_id    = full_reg ? '0 : free_id;
    assign acquire_fire  = acquire_valid && acquire_ready;
    assign count         = count_reg;
    assign empty         = empty_reg;
    assign full          = full_reg;

    always_comb begin
        busy_next  = busy_reg;
        count_next = count_reg;
        if (release_valid) busy_next[release_id] = 1'b0;
        if (acquire_fire)  busy_next[acquire_id] = 1'b1;
        if (acquire_fire && !release_valid) begin
            count_next = count_reg + 1'b1;
        end else if (!acquire_fire && release_valid) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_reg  <= '0;
            count_reg <= '0;
            empty_reg <= 1'b1;
            full_reg  <= 1'b0;
            alive_reg <= 1'b0;
        end else begin
            busy_reg  <= busy_next;
            count_reg <= count_next;
            empty_reg <= (count_next == '0);
            full_reg  <= (count_next == CNTW'(SIZE));
            alive_reg <= 1'b1;
        end
    end

    // Protocol checks only; the datapath does not guard against these.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (free_valid == !full_reg)
                else $error("slot_alloc: encoder valid disagrees with full");
            if (release_valid) begin
                assert (int'(release_id) < SIZE)
                    else $error("slot_alloc: release_id %0d out of range", release_id);
                if (int'(release_id) < SIZE) begin
                    assert (busy_reg[release_id])
                        else $error("slot_alloc: release of free slot %0d", release_id);
                end
            end
        end
    end

endmodule

// File: tb/tb_vx_slot_alloc.sv
// Directed bench for vx_slot_alloc: forward SIZE=4, reverse SIZE=4 and single-slot instances.
module tb_vx_slot_alloc;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // Forward, SIZE=4
    logic       a_av, a_ar, a_rv, a_empty, a_full;
    logic [1:0] a_aid, a_rid;
    logic [2:0] a_cnt;
    // Reverse, SIZE=4
    logic       b_av, b_ar, b_rv, b_empty, b_full;
    logic [1:0] b_aid, b_rid;
    logic [2:0] b_cnt;
    // Single slot
    logic       c_av, c_ar, c_rv, c_empty, c_full;
    logic       c_aid, c_rid;
    logic       c_cnt;

    vx_slot_alloc #(.SIZE(4), .REVERSE(0)) dut_fwd (
        .clk(clk), .reset(reset), .acquire_valid(a_av), .acquire_ready(a_ar),
        .acquire_id(a_aid), .release_valid(a_rv), .release_id(a_rid),
        .count(a_cnt), .empty(a_empty), .full(a_full));

    vx_slot_alloc #(.SIZE(4), .REVERSE(1)) dut_rev (
        .clk(clk), .reset(reset), .acquire_valid(b_av), .acquire_ready(b_ar),
        .acquire_id(b_aid), .release_valid(b_rv), .release_id(b_rid),
        .count(b_cnt), .empty(b_empty), .full(b_full));

    vx_slot_alloc #(.SIZE(1), .REVERSE(0)) dut_one (
        .clk(clk), .reset(reset), .acquire_valid(c_av), .acquire_ready(c_ar),
        .acquire_id(c_aid), .release_valid(c_rv), .release_id(c_rid),
        .count(c_cnt), .empty(c_empty), .full(c_full));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
            else begin
                failed++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    // Advance one cycle; inputs are driven and outputs sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        a_av = 0; a_rv = 0; a_rid = 0;
        b_av = 0; b_rv = 0; b_rid = 0;
        c_av = 0; c_rv = 0; c_rid = 0;
        step(); step();
        check("rst_ready_low", 32'(a_ar), 0);
        check("rst_count", 32'(a_cnt), 0);
        check("rst_empty", 32'(a_empty), 1);
        check("rst_full", 32'(a_full), 0);
        check("rst_rev_id", 32'(b_aid), 3);
        reset = 1'b1;
        step();
        $display("[TB] reset released");

        // Fill the forward table with acquire_valid held.
        check("fwd_ready0", 32'(a_ar), 1);
        a_av = 1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fwd_grant%0d", i), 32'(a_aid), 32'(i));
            check($sformatf("fwd_ready_g%0d", i), 32'(a_ar), 1);
            $display("[TB] fwd acquire id=%0d", a_aid);
            step();
        end
        check("fwd_full", 32'(a_full), 1);
        check("fwd_full_ready", 32'(a_ar), 0);
        check("fwd_full_count", 32'(a_cnt), 4);
        check("fwd_full_id", 32'(a_aid), 0);
        a_av = 0;

        // Release 2 from full: ready stays low this cycle.
        a_rv = 1; a_rid = 2;
        check("rel2_same_cycle_ready", 32'(a_ar), 0);
        $display("[TB] fwd release id=2");
        step();
        check("rel2_ready", 32'(a_ar), 1);
        check("rel2_id", 32'(a_aid), 2);
        check("rel2_count", 32'(a_cnt), 3);
        check("rel2_full", 32'(a_full), 0);

        // Release 3 to reach busy={0,1}.
        a_rid = 3;
        $display("[TB] fwd release id=3");
        step();
        check("b01_count", 32'(a_cnt), 2);
        check("b01_id", 32'(a_aid), 2);

        // Simultaneous acquire and release of 0.
        a_av = 1; a_rv = 1; a_rid = 0;
        check("sim_grant", 32'(a_aid), 2);
        $display("[TB] fwd acquire id=%0d + release id=0", a_aid);
        step();
        a_av = 0; a_rv = 0;
        check("sim_count", 32'(a_cnt), 2);
        check("sim_next_id", 32'(a_aid), 0);
        check("sim_empty", 32'(a_empty), 0);

        // Acquire 0 -> busy={0,1,2}, then reset with a fire pending.
        a_av = 1;
        check("pre_rst_grant", 32'(a_aid), 0);
        step();
        check("pre_rst_count", 32'(a_cnt), 3);
        check("pre_rst_id", 32'(a_aid), 3);
        reset = 1'b0;
        $display("[TB] fwd reset pulse with acquire pending");
        step();
        reset = 1'b1;
        check("mid_rst_count", 32'(a_cnt), 0);
        check("mid_rst_empty", 32'(a_empty), 1);
        check("mid_rst_ready", 32'(a_ar), 0);
        a_av = 0;
        step();
        check("post_rst_ready", 32'(a_ar), 1);
        check("post_rst_id", 32'(a_aid), 0);
        check("post_rst_count", 32'(a_cnt), 0);

        // Reverse instance.
        b_av = 1;
        check("rev_grant0", 32'(b_aid), 3);
        $display("[TB] rev acquire id=%0d", b_aid);
        step();
        check("rev_grant1", 32'(b_aid), 2);
        check("rev_count1", 32'(b_cnt), 1);
        $display("[TB] rev acquire id=%0d", b_aid);
        step();
        b_av = 0; b_rv = 1; b_rid = 3;
        check("rev_count2", 32'(b_cnt), 2);
        check("rev_id_after2", 32'(b_aid), 1);
        $display("[TB] rev release id=3");
        step();
        b_rv = 0;
        check("rev_rel_id", 32'(b_aid), 3);
        check("rev_rel_count", 32'(b_cnt), 1);

        // Single-slot instance.
        check("one_ready", 32'(c_ar), 1);
        check("one_empty0", 32'(c_empty), 1);
        c_av = 1;
        check("one_grant", 32'(c_aid), 0);
        $display("[TB] one acquire id=%0d", c_aid);
        step();
        c_av = 0;
        check("one_full", 32'(c_full), 1);
        check("one_full_ready", 32'(c_ar), 0);
        check("one_full_count", 32'(c_cnt), 1);
        check("one_full_empty", 32'(c_empty), 0);
        c_rv = 1; c_rid = 0;
        $display("[TB] one release id=0");
        step();
        c_rv = 0;
        check("one_rel_empty", 32'(c_empty), 1);
        check("one_rel_full", 32'(c_full), 0);
        check("one_rel_count", 32'(c_cnt), 0);
        check("one_rel_ready", 32'(c_ar), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vx_slot_alloc.md
# VX_slot_alloc

Slot allocator that hands out the lowest-indexed free slot out of `SIZE` slots and accepts slot releases by index. It is the write/fill side of the first-valid selection used across the pipeline: instead of picking the first *occupied* entry, it claims the first *free* one. Typical users are issue and LSU tag tables, MSHR-style tracking structures and writeback queues that need a unique ID per in-flight request. One allocation and one release can complete in the same cycle.

## Interface
- `SIZE`, 8: number of slots, ≥1.
- `REVERSE`, 0: 0 picks the lowest free index; 1 picks the highest free index.
- `LOGS`, `` `UP($clog2(SIZE)) ``: ID width, minimum 1.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset.
- `acquire_valid` in 1: requester wants a slot.
- `acquire_ready` out 1: a free slot exists.
- `acquire_id` out LOGS: granted slot index, valid when `acquire_ready`=1.
- `release_valid` in 1: a slot is being freed.
- `release_id` in LOGS: index of the slot to free.
- `count` out `$clog2(SIZE+1)`: number of busy slots.
- `empty` out 1: `count`==0.
- `full` out 1: `count`==SIZE.

## Operation
- State: `busy[SIZE-1:0]` bitmap and `count` register. `empty` and `full` are registered and updated alongside `count`.
- `acquire_id` is the first zero bit of `busy`, scanning from index 0 (or from SIZE-1 when `REVERSE`=1). It is computed combinationally from the registered `busy`.
- `acquire_ready` = !full. When full, `acquire_id` is driven to 0.
- acquire fire = `acquire_valid` && `acquire_ready`. On fire, `busy[acquire_id]` is set at the next edge.
- On `release_valid`, `busy[release_id]` is cleared at the next edge.
- Simultaneous fire and release: both bitmap updates apply and `count` is unchanged. Otherwise `count` changes by +1 or −1.
- There is no bypass. A slot released in cycle t is not grantable until cycle t+1.
- A granted ID never equals a slot that is currently busy.
- Illegal conditions are simulation-only assertions and are not protected in RTL:
  - Release of a slot that is not busy.
  - `release_id` ≥ SIZE.
  - `acquire_valid` held while `acquire_ready`=0 is legal; the requester simply waits.
- `acquire_ready` does not depend on `acquire_valid` or `release_valid`. There are no combinational paths from any input to any output.

## Timing
- Reset (`reset`=0 at an edge): `busy`=0, `count`=0, `empty`=1, `full`=0. `acquire_ready` is forced to 0 while `reset`=0. `acquire_id`=0 (or SIZE-1 if `REVERSE`).
- The cycle after reset deasserts: `acquire_ready`=1.
- Grant latency is 0 cycles: the ID is presented in the same cycle as fire. The bitmap and `count` update 1 cycle later.
- Back-to-back fires in consecutive cycles receive distinct IDs.
- Throughput: 1 acquire and 1 release per cycle.
- Full boundary: the fire that takes `count` to SIZE makes `full`=1 and `acquire_ready`=0 in the following cycle. A release in that same cycle keeps `full`=0.
- Reset asserted mid-operation discards all outstanding allocations regardless of in-flight fires or releases.

## Structure
- No package typedefs are needed. ID and count widths are derived locally from `SIZE`. `UP` and clog2 come from the platform macros.
- One sub-module: `VX_priority_encoder` (N=SIZE, REVERSE), fed with `~busy`. It outputs the index and a valid bit. Its valid bit must match !full; add an assertion for this.
- The remaining logic is the bitmap, the count register and the assertions in the top module.

## Test plan
- SIZE=4, REVERSE=0: hold `acquire_valid`=1 for 5 cycles -> IDs 0,1,2,3 granted. `full`=1 and `acquire_ready`=0 in cycle 5, and `count`=4.
- From full, release ID 2 -> the next cycle has `acquire_ready`=1 and `acquire_id`=2. In the same cycle as the release, `acquire_ready` is still 0.
- Busy={0,1}: fire acquire and release ID 0 in the same cycle -> grant ID 2. The next cycle has busy={1,2}, `count`=2, and `acquire_id`=0.
- REVERSE=1, SIZE=4: 2 fires -> IDs 3 then 2. Release 3 -> the next `acquire_id`=3.
- Busy={0,1,2} with fire pending: pulse `reset`=0 for one cycle -> `count`=0, `empty`=1, `acquire_ready`=0 during reset, then 1 with `acquire_id`=0.
- Release of a free slot (ID 3 when busy={0}) -> assertion fires. SIZE=1: a single fire sets `full`=1, and its release sets `empty`=1.
